// File: rtl/wide_add_sequencer.sv
// -----------------------------------------------------------------------------
// wide_add_sequencer
//
// Performs a WIDE-bit add (WIDE = B_W*N_WORDS) on one external B_W-bit adder
// slice. The wide operands are latched on start. The slice is then fed one word
// per cycle, least significant word first. The slice carry is chained into the
// next word. The slice results are collected into registered wide results.
//
// Optional feature (macro WIDE_ADD_SUB_EN):
//   This adds a `sub` input. It is latched with the operands. When it is set,
//   the sequencer stores ~op_b and forces the initial carry to 1, so the result
//   is A-B. In that mode, carry_out=1 means no borrow occurred.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   operation request, sampled only while idle
//   op_a/op_b  in   WIDE-bit operands
//   carry_in   in   initial carry into word 0
//   sub        in   (WIDE_ADD_SUB_EN only) subtract request
//   busy       out  high while words are being processed
//   done       out  one-cycle completion pulse
//   sum        out  registered WIDE-bit result
//   carry_out  out  registered carry from the final word
//   overflow   out  registered slice V from the final word
//   add_a/add_b/add_cin  out  word operands and carry to the slice
//   add_f/add_co/add_v   in   slice sum, carry out and overflow
// -----------------------------------------------------------------------------
module wide_add_sequencer #(
  parameter int B_W     = 4,
  parameter int N_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [B_W*N_WORDS-1:0] op_a,
  input  logic [B_W*N_WORDS-1:0] op_b,
  input  logic                   carry_in,
`ifdef WIDE_ADD_SUB_EN
  input  logic                   sub,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [B_W*N_WORDS-1:0] sum,
  output logic                   carry_out,
  output logic                   overflow,
  output logic [B_W-1:0]         add_a,
  output logic [B_W-1:0]         add_b,
  output logic                   add_cin,
  input  logic [B_W-1:0]         add_f,
  input  logic                   add_co,
  input  logic                   add_v
);

  localparam int WIDE  = B_W * N_WORDS;
  localparam int IDX_W = $clog2(N_WORDS);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_r;
  logic [IDX_W-1:0] idx_r;
  logic [WIDE-1:0]  a_r;
  logic [WIDE-1:0]  b_r;
  logic [WIDE-1:0]  sum_r;
  logic             carry_r;
  logic             carry_out_r;
  logic             overflow_r;
  logic             busy_r;
  logic             done_r;

  // Operand conditioning at accept time: subtraction inverts B and forces the
  // initial carry, so the same slice computes A + ~B + 1.
  logic [WIDE-1:0]  b_load_s;
  logic             cin_load_s;

  // Select the B operand and initial carry that are latched on start.
  always_comb begin
    b_load_s   = op_b;
    cin_load_s = carry_in;
`ifdef WIDE_ADD_SUB_EN
    if (sub) begin
      b_load_s   = ~op_b;
      cin_load_s = 1'b1;
    end else begin
      b_load_s   = op_b;
      cin_load_s = carry_in;
    end
`endif
  end

  // Slice feed. The slice inputs are driven only while running, and they come
  // straight from registers so the slice sees stable words for the whole cycle.
  always_comb begin
    add_a   = {B_W{1'b0}};
    add_b   = {B_W{1'b0}};
    add_cin = 1'b0;
    if (state_r == ST_RUN) begin
      add_a   = a_r[idx_r*B_W +: B_W];
      add_b   = b_r[idx_r*B_W +: B_W];
      add_cin = carry_r;
    end else begin
      add_a   = {B_W{1'b0}};
      add_b   = {B_W{1'b0}};
      add_cin = 1'b0;
    end
  end

  // Control FSM and result collection.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      idx_r       <= {IDX_W{1'b0}};
      a_r         <= {WIDE{1'b0}};
      b_r         <= {WIDE{1'b0}};
      sum_r       <= {WIDE{1'b0}};
      carry_r     <= 1'b0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_r     <= op_a;
            b_r     <= b_load_s;
            carry_r <= cin_load_s;
            sum_r   <= {WIDE{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_r[idx_r*B_W +: B_W] <= add_f;
          carry_r                 <= add_co;
          if (idx_r == LAST_IDX) begin
            // The flags come from the most significant word only.
            carry_out_r <= add_co;
            overflow_r  <= add_v;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign sum       = sum_r;
  assign carry_out = carry_out_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_wide_add_sequencer.sv
module tb_wide_add_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        carry_in;
`ifdef WIDE_ADD_SUB_EN
  logic        sub_s;
`endif
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        carry_out;
  logic        overflow;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_f;
  logic        add_co;
  logic        add_v;
  logic [4:0]  slice_s;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic [3:0] cins;

  always #5 clk = ~clk;

  wide_add_sequencer #(.B_W(4), .N_WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .carry_in  (carry_in),
`ifdef WIDE_ADD_SUB_EN
    .sub       (sub_s),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_f     (add_f),
    .add_co    (add_co),
    .add_v     (add_v)
  );

  // Ideal 4-bit slice: carry out and signed overflow.
  always_comb begin
    slice_s = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
    add_f   = slice_s[3:0];
    add_co  = slice_s[4];
    add_v   = (add_a[3] == add_b[3]) && (slice_s[3] != add_a[3]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode 0: plain op, mode 1: start/op_a disturbed during RUN, mode 2: rst at idx 2
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sb, input int mode,
                        output logic [3:0] cin_seq);
    logic [16:0] r;
    logic [15:0] bb;
    logic        c;
    exp_t        e;
    exp_t        got;
    int          busy_cnt;
    int          done_at;
    int          n;
    int          extra_done;
    bb = sb ? ~b : b;
    c  = sb ? 1'b1 : cin;
    r  = {1'b0, a} + {1'b0, bb} + {16'd0, c};
    e.s  = r[15:0];
    e.co = r[16];
    e.ov = (a[15] == bb[15]) && (r[15] != a[15]);
    cin_seq = 4'd0;

    @(negedge clk);
    op_a = a; op_b = b; carry_in = cin; start = 1'b1;
`ifdef WIDE_ADD_SUB_EN
    sub_s = sb;
`endif
    if (mode != 2) sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;

    busy_cnt = 0; done_at = 0; n = 1;
    while (n <= 20 && done_at == 0) begin
      if (busy) begin
        if (busy_cnt < 4) cin_seq[busy_cnt] = add_cin;
        busy_cnt++;
      end
      if (done) done_at = n;
      if (mode == 1 && busy_cnt == 2) begin start = 1'b1; op_a = ~a; end
      if (mode == 1 && busy_cnt == 3) start = 1'b0;
      if (mode == 2 && busy_cnt == 3) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check({tag, "_rst_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_rst_done"}, {31'd0, done}, 32'd0);
        check({tag, "_rst_sum"}, {16'd0, sum}, 32'd0);
        check({tag, "_rst_flags"}, {30'd0, carry_out, overflow}, 32'd0);
        check({tag, "_rst_slice"}, {23'd0, add_a, add_b, add_cin}, 32'd0);
        extra_done = 0;
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          if (done || busy) extra_done++;
        end
        check({tag, "_rst_idle"}, extra_done, 32'd0);
        return;
      end
      if (done_at == 0) begin
        @(negedge clk);
        n++;
      end
    end

    check({tag, "_done_cycle"}, done_at, 32'd5);
    check({tag, "_busy_cycles"}, busy_cnt, 32'd4);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got.s = sum; got.co = carry_out; got.ov = overflow;
      e = sb_q.pop_front();
      check({tag, "_sum"}, {16'd0, got.s}, {16'd0, e.s});
      check({tag, "_cout"}, {31'd0, got.co}, {31'd0, e.co});
      check({tag, "_ovf"}, {31'd0, got.ov}, {31'd0, e.ov});
    end
    extra_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || busy) extra_done++;
    end
    check({tag, "_one_pulse"}, extra_done, 32'd0);
    check({tag, "_hold_sum"}, {16'd0, sum}, {16'd0, e.s});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_a = 16'd0; op_b = 16'd0; carry_in = 1'b0;
`ifdef WIDE_ADD_SUB_EN
    sub_s = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_busy_done", {30'd0, busy, done}, 32'd0);
    check("reset_sum", {16'd0, sum}, 32'd0);
    check("reset_flags", {30'd0, carry_out, overflow}, 32'd0);
    check("reset_slice", {23'd0, add_a, add_b, add_cin}, 32'd0);
    rst = 1'b0;

    run_op("basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, cins);
    check("basic_cin_seq", {28'd0, cins}, 32'h0000_000E);
    check("basic_sum_const", {16'd0, sum}, 32'h0000_2233);

    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, cins);
    check("wrap_const", {15'd0, carry_out, sum}, 32'h0001_0000);
    run_op("cin_only", 16'h0000, 16'h0000, 1'b1, 1'b0, 0, cins);
    check("cin_only_const", {16'd0, sum}, 32'h0000_0001);
    run_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, cins);
    check("pos_ovf_const", {14'd0, carry_out, overflow, sum}, 32'h0001_8000);
    run_op("neg_ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 0, cins);
    check("neg_ovf_const", {14'd0, carry_out, overflow, sum}, 32'h0003_0000);

    run_op("disturb", 16'h4321, 16'h1111, 1'b0, 1'b0, 1, cins);
    check("disturb_const", {16'd0, sum}, 32'h0000_5432);

    run_op("abort", 16'h1234, 16'h1111, 1'b0, 1'b0, 2, cins);
    run_op("after_abort", 16'hA5A5, 16'h1234, 1'b1, 1'b0, 0, cins);

`ifdef WIDE_ADD_SUB_EN
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 0, cins);
    check("sub_neg_const", {15'd0, carry_out, sum}, 32'h0000_FFFE);
    run_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 0, cins);
    check("sub_pos_const", {15'd0, carry_out, sum}, 32'h0001_0002);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
